// File: rtl/shift_right_seq.sv
// Sequential right shifter: shifts a captured operand right by one bit per
// clock, with zero or sign fill, behind a start/busy/done handshake.
module shift_right_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SHW   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_b,
  input  logic             i_arith,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_out
);

  // Counter must hold values 0..WIDTH inclusive.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_work,  w_work_next;
  logic [CntW-1:0]  r_rem,   w_rem_next;
  logic             r_fill,  w_fill_next;
  logic [WIDTH-1:0] r_out,   w_out_next;

  logic [CntW-1:0]  w_eff;
  logic [WIDTH-1:0] w_shifted;
  logic             w_accept;

  // Saturate the requested shift amount at WIDTH.
  always_comb begin
    if (32'(i_b) >= WIDTH) begin
      w_eff = CntW'(WIDTH);
    end else begin
      w_eff = CntW'(i_b);
    end
  end

  assign w_shifted = {r_fill, r_work[WIDTH-1:1]};
  assign w_accept  = (r_state == StIdle) && i_start;

  // Next-state and datapath update logic.
  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_rem_next   = r_rem;
    w_fill_next  = r_fill;
    w_out_next   = r_out;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_work_next = i_a;
          w_fill_next = i_arith & i_a[WIDTH-1];
          w_rem_next  = w_eff;
          if (w_eff == '0) begin
            // Nothing to shift: the operand is already the result.
            w_out_next   = i_a;
            w_state_next = StDone;
          end else begin
            w_state_next = StShift;
          end
        end
      end
      StShift: begin
        w_work_next = w_shifted;
        w_rem_next  = r_rem - 1'b1;
        if (r_rem == CntW'(1)) begin
          w_out_next   = w_shifted;
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_rem   <= '0;
      r_fill  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
      r_rem   <= w_rem_next;
      r_fill  <= w_fill_next;
      r_out   <= w_out_next;
    end
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = (r_state == StDone);
  assign o_out  = r_out;

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Sequential right shifter: the right-shift counterpart to the ALU's combinational left shifter.
- Shifts operand `a` right by `b` positions, one bit per clock.
- Supports logical fill (zeros) or arithmetic fill (sign bit).
- Uses a start/busy/done handshake so the ALU control can launch an operation and collect the result.

Parameters:
- WIDTH, 4, operand and result width in bits.
- SHW, 4, shift-amount width in bits. Any `b` >= WIDTH saturates.

Ports:
- clk    input   1       single clock, all state updates on rising edge
- rst    input   1       reset, synchronous, active-high
- start  input   1       request; sampled only in IDLE
- a      input   WIDTH   operand A, captured on accept
- b      input   SHW     shift amount B, captured on accept
- arith  input   1       0 = logical (zero fill), 1 = arithmetic (fill with a[WIDTH-1]); captured on accept
- busy   output  1       1 while state != IDLE
- done   output  1       one-cycle pulse; out is valid in that cycle
- out    output  WIDTH   result register; holds last result until next done

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, busy=0, done=0, out=0.
  - Working register and counter cleared.
  - Overrides any operation in progress. No done pulse is issued for an aborted operation.
- Accept condition: start=1 while state=IDLE, at rising edge k.
- On accept:
  - Capture a into the working register.
  - Capture fill bit: arith ? a[WIDTH-1] : 0.
  - Compute eff = min(b, WIDTH), saturating, so b >= WIDTH gives eff=WIDTH.
  - Load counter rem = eff.
- State machine (IDLE, SHIFT, DONE):
  - IDLE --accept, eff=0--> DONE.
  - IDLE --accept, eff>0--> SHIFT.
  - SHIFT: each edge does work = {fill, work[WIDTH-1:1]} and rem = rem-1. When rem=1 at the edge, go to DONE.
  - DONE: one cycle only, then IDLE. Leaving DONE does not clear out.
- Outputs are registered:
  - busy=1 in SHIFT and DONE.
  - done=1 only in DONE.
  - out is loaded with the final working value on the edge that enters DONE, so out is valid whenever done=1.
- Latency: done is high in the cycle after edge k+eff, giving eff+1 cycles from accept to the done cycle inclusive.
  - b=0: done in the cycle right after accept edge k.
  - Maximum is WIDTH+1 cycles.
- Start is ignored while busy=1, including the DONE cycle. No queuing: a request must be re-presented once busy=0.
- Back-to-back throughput: a new accept is possible on the first IDLE cycle, one cycle after done.
- Inputs a, b and arith may change freely after accept; only the captured values are used.
- Saturation results:
  - logical with b >= WIDTH gives out=0.
  - arithmetic with b >= WIDTH gives all bits = the sign of a.
- done and busy never assert without a preceding accept. done never lasts more than 1 cycle.
- When rst and start are high on the same edge, rst wins and nothing is accepted.

Test Plan:
- Logical basic: a=4'b1011, b=1, arith=0.
  - Expect out=4'b0101 and done=1 in the cycle after edge k+1.
  - busy=1 for 2 cycles, then busy=0.
- Arithmetic: a=4'b1011, b=2, arith=1 → out=4'b1110 after 3 cycles.
- Arithmetic positive: a=4'b0110, b=3, arith=1 → out=4'b0000.
- Zero shift: a=4'b1001, b=0 → done in the cycle after accept with out=4'b1001; busy high for exactly that one cycle.
- Saturation, logical: a=4'b1111, b=4'd9, arith=0 → out=4'b0000 after 5 cycles.
- Saturation, arithmetic: a=4'b1000, b=4'd15, arith=1 → out=4'b1111 after 5 cycles.
- Busy lockout: launch a=4'b1100, b=3, arith=0.
  - Pulse start with a=4'b0001, b=0 during SHIFT and again during DONE.
  - Expect a single done with out=4'b0001 from the first request; the later requests are ignored.
  - Then start with a=4'b0001, b=0 in IDLE → out=4'b0001.
- Reset mid-operation: start a=4'b1010, b=4, then assert rst on the second SHIFT edge.
  - Next cycle: busy=0, done=0, out=0.
  - No done pulse follows.
  - A fresh request (a=4'b1010, b=1, arith=0) → out=4'b0101.
